// File: rtl/conv_bcd_pkg.sv
// Shared definitions for the packed-BCD to binary converter: field codes, limits, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package conv_bcd_pkg;

    // Field codes carried on campo
    localparam logic [2:0] CAMPO_SEG   = 3'd0;
    localparam logic [2:0] CAMPO_MIN   = 3'd1;
    localparam logic [2:0] CAMPO_HORA  = 3'd2;
    localparam logic [2:0] CAMPO_DIA   = 3'd3;
    localparam logic [2:0] CAMPO_MES   = 3'd4;
    localparam logic [2:0] CAMPO_ANIO  = 3'd5;
    localparam logic [2:0] CAMPO_SEMAN = 3'd6;
    localparam logic [2:0] CAMPO_CRUDO = 3'd7;

    // Legal range per field, inclusive
    localparam logic [6:0] SEG_MIN   = 7'd0;
    localparam logic [6:0] SEG_MAX   = 7'd59;
    localparam logic [6:0] MIN_MIN   = 7'd0;
    localparam logic [6:0] MIN_MAX   = 7'd59;
    localparam logic [6:0] HORA_MIN  = 7'd0;
    localparam logic [6:0] HORA_MAX  = 7'd23;
    localparam logic [6:0] DIA_MIN   = 7'd1;
    localparam logic [6:0] DIA_MAX   = 7'd31;
    localparam logic [6:0] MES_MIN   = 7'd1;
    localparam logic [6:0] MES_MAX   = 7'd12;
    localparam logic [6:0] ANIO_MIN  = 7'd0;
    localparam logic [6:0] ANIO_MAX  = 7'd99;
    localparam logic [6:0] SEMAN_MIN = 7'd1;
    localparam logic [6:0] SEMAN_MAX = 7'd7;
    // Raw field: full 7-bit span so the compare can never fire
    localparam logic [6:0] CRUDO_MIN = 7'd0;
    localparam logic [6:0] CRUDO_MAX = 7'd127;

    typedef struct packed {
        logic [6:0] min;
        logic [6:0] max;
    } limites_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECENAS = 3'd1,
        SUMA    = 3'd2,
        VALIDA  = 3'd3,
        SALIDA  = 3'd4
    } estado_t;

endpackage

// File: rtl/conv_bcd_binario_limite_campo.sv
// Field code to {min, max} legal-range lookup; campo in, lim out.
// Latency: combinational.
// Backpressure: none.
module limite_campo
    import conv_bcd_pkg::*;
(
    input  logic [2:0] campo,
    output limites_t   lim
);

    always_comb begin
        lim = '{min: CRUDO_MIN, max: CRUDO_MAX};
        case (campo)
            CAMPO_SEG:   lim = '{min: SEG_MIN,   max: SEG_MAX};
            CAMPO_MIN:   lim = '{min: MIN_MIN,   max: MIN_MAX};
            CAMPO_HORA:  lim = '{min: HORA_MIN,  max: HORA_MAX};
            CAMPO_DIA:   lim = '{min: DIA_MIN,   max: DIA_MAX};
            CAMPO_MES:   lim = '{min: MES_MIN,   max: MES_MAX};
            CAMPO_ANIO:  lim = '{min: ANIO_MIN,  max: ANIO_MAX};
            CAMPO_SEMAN: lim = '{min: SEMAN_MIN, max: SEMAN_MAX};
            default:     lim = '{min: CRUDO_MIN, max: CRUDO_MAX};
        endcase
    end

endmodule

// File: rtl/conv_bcd_binario.sv
// Packed-BCD byte (tens/units) to 7-bit binary with digit check and, under CONV_BCD_RANGO_EN, per-field range check.
// Latency: out_valid registered on the 4th edge counting the accept edge; initiation interval 5 cycles.
// Backpressure: result held in SALIDA until out_ready; in_ready low from accept until release edge.
// Ports: clk/reset_n; in_valid/in_ready/dato_bcd/campo in; out_valid/out_ready/dato_bin/error_digito/error_rango out.
module conv_bcd_binario
    import conv_bcd_pkg::*;
#(
    parameter logic [6:0] DATO_INVALIDO = 7'h7F
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] dato_bcd,
    input  logic [2:0] campo,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] dato_bin,
    output logic       error_digito,
    output logic       error_rango
);

    estado_t    estado, estado_d;
    logic [3:0] decenas_q, unidades_q;
    logic [6:0] acc_q;
    logic       err_dig_q;
    logic       rango_fuera;
    logic       acepta;
    logic       in_ready_d, out_valid_d, carga_salida;

    assign acepta = (estado == IDLE) && in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) estado <= IDLE;
        else          estado <= estado_d;
    end

    // Next-state logic
    always_comb begin
        estado_d = estado;
        case (estado)
            IDLE:    if (acepta) estado_d = DECENAS;
            DECENAS: estado_d = SUMA;
            SUMA:    estado_d = VALIDA;
            VALIDA:  estado_d = SALIDA;
            SALIDA:  if (out_ready) estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
    end

    // Output decode: handshake outputs are registered from the next state,
    // so in_ready only rises on the first edge after reset is released.
    always_comb begin
        in_ready_d   = (estado_d == IDLE);
        out_valid_d  = (estado_d == SALIDA);
        carga_salida = (estado == VALIDA);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

`ifdef CONV_BCD_RANGO_EN
    logic [2:0] campo_q;
    limites_t   lim;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    campo_q <= 3'd0;
        else if (acepta) campo_q <= campo;
    end

    limite_campo u_limite_campo (
        .campo (campo_q),
        .lim   (lim)
    );

    assign rango_fuera = (acc_q < lim.min) || (acc_q > lim.max);
`else
    logic unused_campo;
    assign unused_campo = ^campo;
    assign rango_fuera  = 1'b0;
`endif

    // Datapath: tens*10 built as tens*8 then + tens*2 + units over two steps.
    // With an invalid nibble acc may wrap, but the result is replaced anyway.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            decenas_q    <= 4'd0;
            unidades_q   <= 4'd0;
            acc_q        <= 7'd0;
            err_dig_q    <= 1'b0;
            dato_bin     <= 7'd0;
            error_digito <= 1'b0;
            error_rango  <= 1'b0;
        end else begin
            if (acepta) begin
                decenas_q  <= dato_bcd[7:4];
                unidades_q <= dato_bcd[3:0];
            end
            if (estado == DECENAS) begin
                acc_q     <= {decenas_q, 3'b000};
                err_dig_q <= (decenas_q > 4'd9) || (unidades_q > 4'd9);
            end
            if (estado == SUMA) begin
                acc_q <= acc_q + {2'b00, decenas_q, 1'b0} + {3'b000, unidades_q};
            end
            if (carga_salida) begin
                dato_bin     <= err_dig_q ? DATO_INVALIDO : acc_q;
                error_digito <= err_dig_q;
                // A bad digit makes the value meaningless, so it masks the range flag
                error_rango  <= !err_dig_q && rango_fuera;
            end
        end
    end

endmodule

// File: tb/tb_conv_bcd_binario.sv
// Directed self-checking bench for conv_bcd_binario (range expectations follow CONV_BCD_RANGO_EN).
// Latency: checks 4-edge result latency and 5-cycle initiation interval.
// Backpressure: holds out_ready low with a pending second byte and checks it waits.
module tb_conv_bcd_binario;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dato_bcd;
    logic [2:0] campo;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] dato_bin;
    logic       error_digito;
    logic       error_rango;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int prev_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_bcd_binario dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dato_bcd     (dato_bcd),
        .campo        (campo),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .dato_bin     (dato_bin),
        .error_digito (error_digito),
        .error_rango  (error_rango)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] bcd, input logic [2:0] cmp);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", int'(in_ready), 1);
        dato_bcd = bcd;
        campo    = cmp;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        chk("accept_drops_ready", int'(in_ready), 0);
    endtask

    task automatic wait_out();
        int lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 3);
    endtask

    task automatic check_out(input string tag, input int eb, input int ed, input int er);
        chk({tag, "_bin"}, int'(dato_bin), eb);
        chk({tag, "_dig"}, int'(error_digito), ed);
        chk({tag, "_rng"}, int'(error_rango), er);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", int'(out_valid), 0);
        chk("release_ready", int'(in_ready), 1);
    endtask

    initial begin
        int rng_exp;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dato_bcd  = 8'h00;
        campo     = 3'd0;

        // Reset state
        #12;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        check_out("rst", 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("post_rst_ready_low", int'(in_ready), 0);
        @(negedge clk);
        chk("post_rst_ready_high", int'(in_ready), 1);

        // Basic conversion
        send(8'h59, 3'd0);
        wait_out();
        check_out("c59", 59, 0, 0);
        release_out();

        // Invalid digits
        send(8'h5A, 3'd5);
        wait_out();
        check_out("c5A", 127, 1, 0);
        release_out();
        send(8'hA3, 3'd5);
        wait_out();
        check_out("cA3", 127, 1, 0);
        release_out();

        // Range checks
`ifdef CONV_BCD_RANGO_EN
        rng_exp = 1;
`else
        rng_exp = 0;
`endif
        send(8'h24, 3'd2);
        wait_out();
        check_out("hora24", 24, 0, rng_exp);
        release_out();
        send(8'h00, 3'd3);
        wait_out();
        check_out("dia00", 0, 0, rng_exp);
        release_out();
        send(8'h12, 3'd4);
        wait_out();
        check_out("mes12", 12, 0, 0);
        release_out();

        // Backpressure with a pending second byte
        send(8'h31, 3'd3);
        wait_out();
        dato_bcd = 8'h45;
        campo    = 3'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_ready", int'(in_ready), 0);
            check_out("bp31", 31, 0, 0);
        end
        release_out();
        send(8'h45, 3'd1);
        wait_out();
        check_out("c45", 45, 0, 0);
        release_out();

        // Reset during SUMA
        send(8'h42, 3'd7);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", int'(in_ready), 0);
        chk("midrst_valid", int'(out_valid), 0);
        check_out("midrst", 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("midrst_rel_ready_low", int'(in_ready), 0);
        @(negedge clk);
        chk("midrst_rel_ready_high", int'(in_ready), 1);
        for (int k = 0; k < 6; k++) begin
            chk("midrst_no_out", int'(out_valid), 0);
            @(negedge clk);
        end

        // Back-to-back stream of all valid codes
        for (int i = 0; i < 100; i++) begin
            logic [7:0] b;
            b = 8'(((i / 10) << 4) | (i % 10));
            send(b, 3'd7);
            if (i > 0) chk("stream_spacing", acc_cyc - prev_acc, 5);
            wait_out();
            check_out("stream", i, 0, 0);
            release_out();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
